regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arb_pkg.sv | 32 +++
 rtl/regfile_store.sv | 46 ++++
 rtl/regfile_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the round-robin register-file arbiter.
package regfile_arb_pkg;

    localparam int DW_DEF   = 8;
    localparam int NREG_DEF = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    // Round-robin pick between two requesters: on a tie the one not granted
    // last wins; a lone request wins outright. Only called with req != 0.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic win;
        if (req == 2'b11) begin
            win = ~last;
        end else begin
            win = req[1];
        end
        return win;
    endfunction

endpackage

// File: rtl/regfile_store.sv
// NREG x DW register storage: one write port, one swap port, two async reads.
module regfile_store
    import regfile_arb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     swap_en,
    input  logic [$clog2(NREG)-1:0]  swap_a,
    input  logic [$clog2(NREG)-1:0]  swap_b,
    input  logic [DW-1:0]            swap_da,
    input  logic [DW-1:0]            swap_db,
    input  logic [$clog2(NREG)-1:0]  raddr0,
    output logic [DW-1:0]            rdata0,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [DW-1:0]            rdata1
);

    logic [DW-1:0] rf_q [NREG];

    // Storage update: reset clears everything, otherwise write or swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we) begin
            rf_q[waddr] <= wdata;
        end else if (swap_en) begin
            rf_q[swap_a] <= swap_da;
            rf_q[swap_b] <= swap_db;
        end
    end

    // Asynchronous read ports.
    always_comb begin
        rdata0 = rf_q[raddr0];
        rdata1 = rf_q[raddr1];
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a small register file.
// IDLE -> EXEC -> DONE handshake; operands are latched at grant.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req,
    input  logic [1:0]               op0,
    input  logic [1:0]               op1,
    input  logic [$clog2(NREG)-1:0]  addr_a0,
    input  logic [$clog2(NREG)-1:0]  addr_a1,
    input  logic [$clog2(NREG)-1:0]  addr_b0,
    input  logic [$clog2(NREG)-1:0]  addr_b1,
    input  logic [DW-1:0]            wdata0,
    input  logic [DW-1:0]            wdata1,
    output logic [1:0]               gnt,
    output logic [1:0]               done,
    output logic [DW-1:0]            rdata,
    output logic                     busy
);

    localparam int AW = $clog2(NREG);

    state_e          state_q, state_d;
    logic            win_q, win_d;
    logic            last_q, last_d;
    op_e             op_q, op_d;
    logic [AW-1:0]   a_q, a_d;
    logic [AW-1:0]   b_q, b_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            we;
    logic            swap_en;
    logic [DW-1:0]   rd_a;
    logic [DW-1:0]   rd_b;

    // Swap is performed by writing each old value into the other slot, both
    // read combinationally from the latched addresses before the edge.
    regfile_store #(
        .DW   (DW),
        .NREG (NREG)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (a_q),
        .wdata   (wd_q),
        .swap_en (swap_en),
        .swap_a  (a_q),
        .swap_b  (b_q),
        .swap_da (rd_b),
        .swap_db (rd_a),
        .raddr0  (a_q),
        .rdata0  (rd_a),
        .raddr1  (b_q),
        .rdata1  (rd_b)
    );

    // State, operand latches, round-robin pointer and read result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, operand capture and handshake outputs.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        gnt     = '0;
        done    = '0;
        we      = 1'b0;
        swap_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    win_d = rr_pick(req, last_q);
                    if (win_d) begin
                        op_d = op_e'(op1);
                        a_d  = addr_a1;
                        b_d  = addr_b1;
                        wd_d = wdata1;
                    end else begin
                        op_d = op_e'(op0);
                        a_d  = addr_a0;
                        b_d  = addr_b0;
                        wd_d = wdata0;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                gnt[win_q] = 1'b1;
                case (op_q)
                    OP_READ:  rdata_d = rd_a;
                    OP_WRITE: we      = 1'b1;
                    OP_SWAP:  swap_en = (a_q != b_q);
                    default:  ;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                gnt[win_q]  = 1'b1;
                done[win_q] = 1'b1;
                last_d      = win_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: transaction-level model compared every cycle,
// plus literal checks on the directed scenarios.
module tb_regfile_arbiter;

    localparam int DW   = 8;
    localparam int NREG = 4;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] NP = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = '0;
    logic [1:0]    op0 = NP, op1 = NP;
    logic [1:0]    addr_a0 = '0, addr_a1 = '0, addr_b0 = '0, addr_b1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]    gnt, done;
    logic [DW-1:0] rdata;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_arbiter #(.DW(DW), .NREG(NREG)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op0     (op0),
        .op1     (op1),
        .addr_a0 (addr_a0),
        .addr_a1 (addr_a1),
        .addr_b0 (addr_b0),
        .addr_b1 (addr_b1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt     (gnt),
        .done    (done),
        .rdata   (rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase counts cycles since the grant: 0 idle, 1 operation cycle, 2 done cycle.
    int            m_phase = 0;
    int            m_win = 0;
    int            m_last = 1;
    logic [1:0]    m_op;
    int            m_a, m_b;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rf [NREG];
    logic [DW-1:0] m_rdata = '0;
    bit            m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_last  = 1;
            m_rdata = '0;
            for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            m_valid = 1;
        end else if (m_phase == 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_win = 1 - m_last;
                else              m_win = req[1] ? 1 : 0;
                m_op   = m_win ? op1 : op0;
                m_a    = m_win ? int'(addr_a1) : int'(addr_a0);
                m_b    = m_win ? int'(addr_b1) : int'(addr_b0);
                m_wd   = m_win ? wdata1 : wdata0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_op == RD) m_rdata = m_rf[m_a];
            else if (m_op == WR) m_rf[m_a] = m_wd;
            else if (m_op == SW) begin
                logic [DW-1:0] t;
                t = m_rf[m_a];
                m_rf[m_a] = m_rf[m_b];
                m_rf[m_b] = t;
            end
            m_phase = 2;
        end else begin
            m_last  = m_win;
            m_phase = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [1:0] e_gnt, e_done;
            e_gnt  = (m_phase != 0) ? 2'(1 << m_win) : 2'b00;
            e_done = (m_phase == 2) ? 2'(1 << m_win) : 2'b00;
            n_cmp += 4;
            if (gnt !== e_gnt) begin
                n_bad++;
                $display("FAIL model_gnt t=%0t got=%b want=%b", $time, gnt, e_gnt);
            end
            if (done !== e_done) begin
                n_bad++;
                $display("FAIL model_done t=%0t got=%b want=%b", $time, done, e_done);
            end
            if (busy !== (m_phase != 0)) begin
                n_bad++;
                $display("FAIL model_busy t=%0t got=%b want=%b", $time, busy, m_phase != 0);
            end
            if (rdata !== m_rdata) begin
                n_bad++;
                $display("FAIL model_rdata t=%0t got=%h want=%h", $time, rdata, m_rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic set_ops(input int who, input logic [1:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic [DW-1:0] wd);
        if (who == 0) begin
            op0 = op; addr_a0 = a; addr_b0 = b; wdata0 = wd;
        end else begin
            op1 = op; addr_a1 = a; addr_b1 = b; wdata1 = wd;
        end
    endtask

    // One full operation from IDLE: request, EXEC, DONE, back to IDLE.
    task automatic issue(input int who, input logic [1:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic [DW-1:0] wd);
        set_ops(who, op, a, b, wd);
        req = 2'(1 << who);
        cyc();
        req = '0;
        cyc();
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_gnt",   32'(gnt),   32'h0);
        chk("reset_busy",  32'(busy),  32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);

        // Write A5 to reg 2 with exact latency checks.
        set_ops(0, WR, 2'd2, 2'd0, 8'hA5);
        req = 2'b01;
        cyc();
        req = '0;
        chk("w_exec_gnt",  32'(gnt),  32'h1);
        chk("w_exec_done", 32'(done), 32'h0);
        cyc();
        chk("w_done_done", 32'(done), 32'h1);
        chk("w_done_gnt",  32'(gnt),  32'h1);
        cyc();
        chk("w_idle_done", 32'(done), 32'h0);
        chk("w_idle_busy", 32'(busy), 32'h0);
        issue(1, RD, 2'd2, 2'd0, 8'h00);
        chk("read_a5", 32'(rdata), 32'hA5);
        issue(0, RD, 2'd0, 2'd0, 8'h00);
        chk("read_unwritten", 32'(rdata), 32'h00);

        // Swap distinct registers.
        issue(0, WR, 2'd0, 2'd0, 8'h11);
        issue(1, WR, 2'd3, 2'd0, 8'h33);
        issue(1, SW, 2'd0, 2'd3, 8'h00);
        issue(0, RD, 2'd0, 2'd0, 8'h00);
        chk("swap_r0", 32'(rdata), 32'h33);
        issue(0, RD, 2'd3, 2'd0, 8'h00);
        chk("swap_r3", 32'(rdata), 32'h11);

        // Swap a register with itself, then a NOP.
        issue(0, WR, 2'd1, 2'd0, 8'h5A);
        issue(0, SW, 2'd1, 2'd1, 8'h00);
        issue(1, RD, 2'd1, 2'd0, 8'h00);
        chk("selfswap_r1", 32'(rdata), 32'h5A);
        issue(0, NP, 2'd3, 2'd0, 8'hEE);
        chk("nop_rdata", 32'(rdata), 32'h5A);
        issue(0, RD, 2'd3, 2'd0, 8'h00);
        chk("nop_r3_kept", 32'(rdata), 32'h11);

        // Continuous tie after reset: grants alternate starting at requester 0.
        do_reset();
        set_ops(0, WR, 2'd1, 2'd0, 8'h10);
        set_ops(1, WR, 2'd2, 2'd0, 8'h20);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), (k % 2) ? 32'h2 : 32'h1);
            cyc();
            chk($sformatf("rr_done%0d", k), 32'(done), (k % 2) ? 32'h2 : 32'h1);
            cyc();
        end
        req = '0;
        issue(0, RD, 2'd1, 2'd0, 8'h00);
        chk("rr_r1", 32'(rdata), 32'h10);
        issue(0, RD, 2'd2, 2'd0, 8'h00);
        chk("rr_r2", 32'(rdata), 32'h20);

        // Reset during EXEC of a write: no done, no update.
        set_ops(0, WR, 2'd1, 2'd0, 8'hFF);
        req = 2'b01;
        cyc();
        req   = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_exec_busy", 32'(busy), 32'h0);
        chk("rst_exec_gnt",  32'(gnt),  32'h0);
        chk("rst_exec_done", 32'(done), 32'h0);
        issue(1, RD, 2'd1, 2'd0, 8'h00);
        chk("rst_exec_r1", 32'(rdata), 32'h00);

        // Operands changed after grant are ignored.
        set_ops(0, WR, 2'd0, 2'd0, 8'h77);
        req = 2'b01;
        cyc();
        wdata0  = 8'h99;
        addr_a0 = 2'd3;
        op0     = NP;
        req     = '0;
        cyc();
        chk("late_done", 32'(done), 32'h1);
        cyc();
        issue(0, RD, 2'd0, 2'd0, 8'h00);
        chk("late_r0", 32'(rdata), 32'h77);
        issue(0, RD, 2'd3, 2'd0, 8'h00);
        chk("late_r3", 32'(rdata), 32'h00);

        // Single request from 1 after 0 was last served, then a tie (1 was last, so 0 wins).
        issue(1, WR, 2'd3, 2'd0, 8'hC3);
        set_ops(0, RD, 2'd3, 2'd0, 8'h00);
        set_ops(1, WR, 2'd3, 2'd0, 8'h3C);
        req = 2'b11;
        cyc();
        req = 2'b10;
        chk("tie_gnt", 32'(gnt), 32'h1);
        cyc();
        cyc();
        cyc();
        req = '0;
        chk("tie_next_gnt", 32'(gnt), 32'h2);
        cyc();
        cyc();
        chk("tie_rdata", 32'(rdata), 32'hC3);
        issue(0, RD, 2'd3, 2'd0, 8'h00);
        chk("tie_r3", 32'(rdata), 32'h3C);

        // Final readback of all registers through the model.
        for (int i = 0; i < NREG; i++) begin
            issue(i % 2, RD, 2'(i), 2'd0, 8'h00);
        end

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
